// File: rtl/vga_pattern_gen.sv
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : 640x480 pattern stage (bars / checker / bouncing box / solid),
//            two-cycle pipeline with syncs aligned to rgb. Optional macro
//            VGA_PATTERN_BORDER_EN draws a white one-pixel frame border.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_pattern_gen #(
  parameter int          BOX_SIZE  = 32,
  parameter int          SPEED     = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF80,
  parameter logic [11:0] BG_COLOR  = 12'h008
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [9:0]  coord_x,
  input  logic [9:0]  coord_y,
  input  logic        active_area,
  input  logic [1:0]  mode_sel,
  input  logic [11:0] solid_color,
  output logic [11:0] rgb,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        frame_tick
);

  localparam logic [1:0]  c_mode_bars    = 2'd0;
  localparam logic [1:0]  c_mode_checker = 2'd1;
  localparam logic [1:0]  c_mode_box     = 2'd2;
  localparam logic [1:0]  c_mode_solid   = 2'd3;
  localparam logic [10:0] c_lim_x        = 11'(640 - BOX_SIZE);
  localparam logic [10:0] c_lim_y        = 11'(480 - BOX_SIZE);
  localparam logic [10:0] c_speed        = 11'(SPEED);
  localparam logic [10:0] c_box_size     = 11'(BOX_SIZE);

  logic [9:0]  r_x, r_y;
  logic        r_act, r_hs, r_vs, r_tick;
  logic [1:0]  r_mode_in, r_mode;
  logic [11:0] r_solid_in, r_solid;
  logic [9:0]  r_box_x, r_box_y;
  logic        r_neg_x, r_neg_y;
  logic [10:0] w_next_x, w_next_y;
  logic        w_in_box;
  logic [11:0] w_bar, w_color;

  // Returns {direction_is_negative, next_position} for one axis.
  function automatic logic [10:0] next_axis(input logic [9:0] pos,
                                            input logic neg,
                                            input logic [10:0] lim);
    logic [10:0] sum;
    logic [10:0] res;
    sum = {1'b0, pos} + c_speed;
    if (!neg) begin
      if (sum >= lim) res = {1'b1, lim[9:0]};
      else            res = {1'b0, sum[9:0]};
    end else begin
      if ({1'b0, pos} <= c_speed) res = 11'd0;
      else                        res = {1'b1, pos - c_speed[9:0]};
    end
    return res;
  endfunction

  assign w_next_x   = next_axis(r_box_x, r_neg_x, c_lim_x);
  assign w_next_y   = next_axis(r_box_y, r_neg_y, c_lim_y);
  assign frame_tick = r_tick;

  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_act      <= 1'b0;
      r_hs       <= 1'b0;
      r_vs       <= 1'b0;
      r_tick     <= 1'b0;
      r_mode_in  <= '0;
      r_solid_in <= '0;
    end else begin
      r_x        <= coord_x;
      r_y        <= coord_y;
      r_act      <= active_area;
      r_hs       <= h_sync_in;
      r_vs       <= v_sync_in;
      r_tick     <= (coord_x == 10'd0) && (coord_y == 10'd480);
      r_mode_in  <= mode_sel;
      r_solid_in <= solid_color;
    end
  end

  // Frame-boundary state: mode, colour and box move together on the tick.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      r_mode  <= c_mode_bars;
      r_solid <= '0;
      r_box_x <= '0;
      r_box_y <= '0;
      r_neg_x <= 1'b0;
      r_neg_y <= 1'b0;
    end else if (r_tick) begin
      r_mode  <= r_mode_in;
      r_solid <= r_solid_in;
      r_box_x <= w_next_x[9:0];
      r_neg_x <= w_next_x[10];
      r_box_y <= w_next_y[9:0];
      r_neg_y <= w_next_y[10];
    end
  end

  always_comb begin
    w_bar = 12'h000;
    if      (r_x < 10'd80)  w_bar = 12'hFFF;
    else if (r_x < 10'd160) w_bar = 12'hFF0;
    else if (r_x < 10'd240) w_bar = 12'h0FF;
    else if (r_x < 10'd320) w_bar = 12'h0F0;
    else if (r_x < 10'd400) w_bar = 12'hF0F;
    else if (r_x < 10'd480) w_bar = 12'hF00;
    else if (r_x < 10'd560) w_bar = 12'h00F;
    else                    w_bar = 12'h000;
  end

  assign w_in_box = ({1'b0, r_x} >= {1'b0, r_box_x}) &&
                    ({1'b0, r_x} <  ({1'b0, r_box_x} + c_box_size)) &&
                    ({1'b0, r_y} >= {1'b0, r_box_y}) &&
                    ({1'b0, r_y} <  ({1'b0, r_box_y} + c_box_size));

  always_comb begin
    w_color = 12'h000;
    case (r_mode)
      c_mode_bars:    w_color = w_bar;
      c_mode_checker: w_color = (r_x[5] ^ r_y[5]) ? 12'hFFF : 12'h000;
      c_mode_box:     w_color = w_in_box ? BOX_COLOR : BG_COLOR;
      c_mode_solid:   w_color = r_solid;
      default:        w_color = 12'h000;
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((r_x == 10'd0) || (r_x == 10'd639) || (r_y == 10'd0) || (r_y == 10'd479))
      w_color = 12'hFFF;
`endif
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      rgb        <= '0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      rgb        <= r_act ? w_color : 12'h000;
      h_sync_out <= r_hs;
      v_sync_out <= r_vs;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// ============================================================================
// Module   : tb_vga_pattern_gen
// Brief    : Directed bench for vga_pattern_gen with hand-computed pixels.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_pattern_gen;

  logic        clk_25 = 1'b0;
  logic        reset;
  logic        h_sync_in, v_sync_in, active_area;
  logic [9:0]  coord_x, coord_y;
  logic [1:0]  mode_sel;
  logic [11:0] solid_color;
  logic [11:0] rgb;
  logic        h_sync_out, v_sync_out, frame_tick;

  int n_total = 0;
  int n_bad   = 0;
  int tick_cnt = 0;
  int t0;

  vga_pattern_gen dut (
    .clk_25      (clk_25),
    .reset       (reset),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .active_area (active_area),
    .mode_sel    (mode_sel),
    .solid_color (solid_color),
    .rgb         (rgb),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .frame_tick  (frame_tick)
  );

  always #20 clk_25 = ~clk_25;

  always @(negedge clk_25) if (frame_tick) tick_cnt++;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int x, input int y);
    coord_x     = 10'(x);
    coord_y     = 10'(y);
    active_area = (x < 640) && (y < 480);
    h_sync_in   = 1'b0;
    v_sync_in   = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input logic [11:0] exp, input string tag);
    set_in(x, y);
    @(posedge clk_25); #1;
    set_in(1, 481);
    @(posedge clk_25); #1;
    chk(tag, rgb, exp);
  endtask

  task automatic do_tick();
    set_in(0, 480);
    @(posedge clk_25); #1;
    set_in(1, 480);
    @(posedge clk_25); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_25); #1;
    @(posedge clk_25); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mode_sel = 2'd2;
    solid_color = 12'h000;
    set_in(5, 5);
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_25); #1;
      chk("rst_rgb", rgb, 12'h000);
      chk("rst_hs", {11'd0, h_sync_out}, 12'd0);
      chk("rst_vs", {11'd0, v_sync_out}, 12'd0);
    end
    reset = 1'b0;

    // First frame after reset renders bars even though box is requested.
    probe(0,   100, 12'hFFF, "bars_x0");
    probe(79,  100, 12'hFFF, "bars_x79");
    probe(80,  100, 12'hFF0, "bars_x80");
    probe(559, 100, 12'h00F, "bars_x559");
    probe(639, 100, 12'h000, "bars_x639");
    probe(700, 100, 12'h000, "bars_blank700");

    set_in(79, 100);
    @(posedge clk_25); #1;
    set_in(80, 100);
    h_sync_in = 1'b1;
    @(posedge clk_25); #1;
    chk("lat_rgb_79", rgb, 12'hFFF);
    chk("lat_hs_0", {11'd0, h_sync_out}, 12'd0);
    set_in(81, 100);
    @(posedge clk_25); #1;
    chk("lat_rgb_80", rgb, 12'hFF0);
    chk("lat_hs_1", {11'd0, h_sync_out}, 12'd1);

    mode_sel = 2'd1;
    t0 = tick_cnt;
    do_tick();
    chk("tick_one", 12'(tick_cnt - t0), 12'd1);
    probe(0,  0,  12'h000, "chk_0_0");
    probe(32, 0,  12'hFFF, "chk_32_0");
    probe(32, 32, 12'h000, "chk_32_32");

    mode_sel = 2'd0;
    do_tick();
    mode_sel = 2'd3;
    solid_color = 12'h0A5;
    probe(0,   200, 12'hFFF, "midframe_bar0");
    probe(100, 200, 12'hFF0, "midframe_bar1");
    do_tick();
    probe(0,   0,   12'h0A5, "solid_0_0");
    probe(320, 240, 12'h0A5, "solid_mid");
    probe(639, 479, 12'h0A5, "solid_corner");
    probe(700, 10,  12'h000, "solid_hblank");
    probe(5,   500, 12'h000, "solid_vblank");

    // Box motion from a fresh reset: hand-computed positions per tick.
    do_reset();
    mode_sel = 2'd2;
    t0 = tick_cnt;
    repeat (224) do_tick();
    probe(448, 448, 12'hF80, "box224_tl");
    probe(479, 479, 12'hF80, "box224_br");
    probe(480, 448, 12'h008, "box224_right");
    probe(448, 447, 12'h008, "box224_above");
    repeat (80) do_tick();
    probe(608, 288, 12'hF80, "box304_tl");
    probe(639, 319, 12'hF80, "box304_br");
    probe(607, 288, 12'h008, "box304_left");
    probe(608, 287, 12'h008, "box304_above");
    do_tick();
    probe(606, 286, 12'hF80, "box305_tl");
    probe(638, 286, 12'h008, "box305_right");
    repeat (95) do_tick();
    probe(416, 96,  12'hF80, "box400_tl");
    probe(415, 96,  12'h008, "box400_left");
    chk("tick_count400", 12'(tick_cnt - t0), 12'd400);

    mode_sel = 2'd3;
    solid_color = 12'h000;
    do_tick();
`ifdef VGA_PATTERN_BORDER_EN
    probe(0,   200, 12'hFFF, "border_x0");
    probe(639, 200, 12'hFFF, "border_x639");
    probe(300, 0,   12'hFFF, "border_y0");
    probe(300, 479, 12'hFFF, "border_y479");
    probe(1,   1,   12'h000, "border_inner");
`else
    probe(0,   0,   12'h000, "noborder_0_0");
    probe(1,   1,   12'h000, "noborder_1_1");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-generation stage directly downstream of the 640x480 VGA timing controller; consumes its registered coord_x/coord_y/active_area/h_sync/v_sync and drives 12-bit RGB to the DAC/pins.
- Four display modes: colour bars, checkerboard, bouncing box, solid colour.
- Mode and solid colour are applied only at frame boundaries so the picture never tears.
- Syncs are re-pipelined so RGB and sync leave the block aligned.

Parameters:
- BOX_SIZE, 32, bouncing box edge length in pixels (1..128).
- SPEED, 2, box displacement per frame on each axis, in pixels (1..15).
- BOX_COLOR, 12'hF80, box colour (RGB444).
- BG_COLOR, 12'h008, background colour in box mode.

Ports:
- clk_25  input  1  25 MHz pixel clock
- reset  input  1  synchronous, active-high
- h_sync_in  input  1  from timing controller, high during sync pulse
- v_sync_in  input  1  from timing controller, high during sync pulse
- coord_x  input  10  current pixel column, 0..799
- coord_y  input  10  current line, 0..524
- active_area  input  1  high when the pixel is visible
- mode_sel  input  2  requested mode: 0 bars, 1 checker, 2 box, 3 solid
- solid_color  input  12  colour for mode 3
- rgb  output  12  {R[3:0],G[3:0],B[3:0]}, registered
- h_sync_out  output  1  h_sync_in delayed to match rgb
- v_sync_out  output  1  v_sync_in delayed to match rgb
- frame_tick  output  1  one-cycle pulse at the frame update point

Behaviour:
- Reset:
  - rgb=0, h_sync_out=0, v_sync_out=0, frame_tick=0.
  - mode_q=0, solid_q=0, box_x=0, box_y=0, dir_x=+, dir_y=+.
  - All pipeline registers cleared.
- Pipeline:
  - Stage 1 registers all inputs.
  - Stage 2 computes and registers rgb and syncs.
  - Fixed latency is 2 clk_25 cycles from input to rgb/h_sync_out/v_sync_out, identical for all three.
- Frame update point:
  - Occurs when stage-1 coord_x==0 and coord_y==480 (first blanking line). frame_tick is high for exactly that cycle.
  - On this cycle: mode_q<=mode_sel, solid_q<=solid_color, and the box position is updated.
  - mode_sel and solid_color changes mid-frame have no visible effect until the next update point.
- Blanking: rgb=0 whenever stage-1 active_area==0, regardless of mode.
- Mode 0 (colour bars):
  - 8 bars, each 80 px wide. Bar index k is derived from coord_x by comparison against multiples of 80.
  - Colours k=0..7: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Mode 1 (checkerboard): coord_x[5]^coord_y[5] selects FFF when 1, 000 when 0 (32 px squares).
- Mode 2 (box):
  - Output BOX_COLOR when box_x<=x<box_x+BOX_SIZE and box_y<=y<box_y+BOX_SIZE; otherwise BG_COLOR.
  - Compares are 11-bit to avoid overflow.
- Mode 3 (solid): rgb=solid_q.
- Box motion, per axis, with limit L = 640-BOX_SIZE (x) or 480-BOX_SIZE (y):
  - dir + and pos+SPEED>=L: pos<=L, dir<=-.
  - dir − and pos<=SPEED: pos<=0, dir<=+.
  - Otherwise pos<=pos±SPEED.
  - The box never leaves the active area. The corner case reverses both axes on the same frame.
- Box position updates every frame regardless of the current mode, so motion stays continuous when the mode is switched back to box.
- Reset mid-frame: all state returns to its reset values on the next clock. Output resumes with correct alignment as soon as the controller restarts from (0,0).

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: when active and x==0, x==639, y==0 or y==479, rgb=FFF, overriding every mode. This is used for monitor geometry alignment.
- Undefined: no border logic; the pattern is rendered edge to edge.

Test Plan:
- Reset held 3 cycles with mode_sel=2, then driven by a real controller model -> rgb=0 and both syncs=0 during reset; after release the first frame renders mode 0 until the first frame_tick.
- Mode 0, probe line y=100 -> x=0..79 gives FFF, x=80 gives FF0, x=639 gives 000; rgb=000 at x=640..799; rgb changes exactly 2 cycles after coord_x crosses 80.
- Mode 1 -> (0,0)=000, (32,0)=FFF, (32,32)=000; inject h_sync_in edge -> h_sync_out edge exactly 2 cycles later, coincident with the rgb pipeline.
- Mode 2, BOX_SIZE=32, SPEED=2, run 400 frames -> box_x reaches 608 and reverses; box_y reaches 448 and reverses; box_x/box_y never exceed limits; frame_tick count=400.
- Change mode_sel 0->3 with solid_color=0A5 at line 200 -> remainder of the frame is still bars; from the frame after the tick, every active pixel is 0A5.
- With VGA_PATTERN_BORDER_EN, mode 3, solid 000 -> pixels at x=0, x=639, y=0, y=479 are FFF and (1,1) is 000; without the macro, (0,0) is 000.
